// File: rtl/add_pkg.sv
// ============================================================================
// Module   : add_pkg
// Brief    : Shared constants, depth helper and pipeline stage record for
//            the chunked adder. Sign fields exist only with ADD_OVF_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_pkg;

    localparam int ADD_WIDTH = 27;
    localparam int ADD_CHUNK = 9;

    function automatic int nstg(input int width, input int chunk);
        return width / chunk;
    endfunction

    // a_hi/b_hi hold the still-unresolved operand bits shifted down so the
    // next slice to add always sits at [CHUNK-1:0].
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [ADD_WIDTH-1:0] sum_lo;
        logic [ADD_WIDTH-1:0] a_hi;
        logic [ADD_WIDTH-1:0] b_hi;
`ifdef ADD_OVF_FLAG_EN
        logic                 sa;
        logic                 sb;
`endif
    } add_stage_t;

endpackage

`default_nettype wire

// File: rtl/add_chunk.sv
// ============================================================================
// Module   : add_chunk
// Brief    : CHUNK-bit combinational ripple slice with carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_chunk #(
    parameter int CHUNK = 9
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_s,
    output logic             o_co
);

    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_ci};

endmodule

`default_nettype wire

// File: rtl/add27_pipe.sv
// ============================================================================
// Module   : add27_pipe
// Brief    : Pipelined WIDTH-bit adder resolving one CHUNK slice per stage,
//            valid/ready on both sides. Define ADD_OVF_FLAG_EN for ovf output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add27_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int CHUNK = ADD_CHUNK
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADD_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTG = nstg(WIDTH, CHUNK);

    add_stage_t       r_stg [NSTG];
    add_stage_t       w_src [NSTG];
    add_stage_t       w_nxt [NSTG];
    logic [CHUNK-1:0] w_cs  [NSTG];
    logic             w_co  [NSTG];
    logic             w_adv;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_adv    = !r_stg[NSTG-1].valid || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_src[0]        = '0;
        w_src[0].valid  = in_valid;
        w_src[0].carry  = cin;
        w_src[0].a_hi   = a;
        w_src[0].b_hi   = b;
`ifdef ADD_OVF_FLAG_EN
        w_src[0].sa     = a[WIDTH-1];
        w_src[0].sb     = b[WIDTH-1];
`endif
        for (int k = 1; k < NSTG; k++) begin
            w_src[k] = r_stg[k-1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        add_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .i_a  (w_src[k].a_hi[CHUNK-1:0]),
            .i_b  (w_src[k].b_hi[CHUNK-1:0]),
            .i_ci (w_src[k].carry),
            .o_s  (w_cs[k]),
            .o_co (w_co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            w_nxt[k]        = w_src[k];
            w_nxt[k].carry  = w_co[k];
            w_nxt[k].sum_lo = w_src[k].sum_lo
                            | ({{(WIDTH-CHUNK){1'b0}}, w_cs[k]} << (k * CHUNK));
            w_nxt[k].a_hi   = w_src[k].a_hi >> CHUNK;
            w_nxt[k].b_hi   = w_src[k].b_hi >> CHUNK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSTG; k++) begin
                r_stg[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NSTG; k++) begin
                r_stg[k] <= w_nxt[k];
            end
        end
    end

    assign out_valid = r_stg[NSTG-1].valid;
    assign s         = r_stg[NSTG-1].sum_lo;
    assign cout      = r_stg[NSTG-1].carry;

`ifdef ADD_OVF_FLAG_EN
    assign ovf = (r_stg[NSTG-1].sa == r_stg[NSTG-1].sb)
               && (r_stg[NSTG-1].sum_lo[WIDTH-1] != r_stg[NSTG-1].sa);
`endif

endmodule

`default_nettype wire

// File: tb/tb_add27_pipe.sv
// ============================================================================
// Module   : tb_add27_pipe
// Brief    : Directed and random self-checking bench for add27_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add27_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] a;
    logic [26:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] s;
    logic        cout;
`ifdef ADD_OVF_FLAG_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    add27_pipe u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef ADD_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: accept edge, then result after the third edge.
    task automatic run_op(input string tag, input logic [26:0] va, input logic [26:0] vb,
                          input logic vc, input logic [26:0] es, input logic ec, input logic eo);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        tick();
        in_valid = 1'b0;
        check({tag, "_ov_lat1"}, 64'(out_valid), 64'(0));
        tick();
        check({tag, "_ov_lat2"}, 64'(out_valid), 64'(0));
        tick();
        check({tag, "_ov"},   64'(out_valid), 64'(1));
        check({tag, "_s"},    64'(s),         64'(es));
        check({tag, "_cout"}, 64'(cout),      64'(ec));
`ifdef ADD_OVF_FLAG_EN
        check({tag, "_ovf"},  64'(ovf),       64'(eo));
`else
        if (eo) begin end
`endif
        tick();
        check({tag, "_ov_drain"}, 64'(out_valid), 64'(0));
    endtask

    task automatic stream(input string tag, input int n, input bit rnd);
        logic [27:0] q[$];
        logic [27:0] e;
        logic [26:0] held;
        bit          was_stalled;
        int          sent;
        int          rcv;
        sent        = 0;
        rcv         = 0;
        held        = '0;
        was_stalled = 1'b0;
        for (int cyc = 0; cyc < n * 8 + 100 && rcv < n; cyc++) begin
            if (sent < n) begin
                if (rnd) begin
                    in_valid = 1'($urandom_range(0, 1));
                    a        = 27'($urandom());
                    b        = 27'($urandom());
                    cin      = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b1;
                    a        = 27'(sent * 32'h00ABCDE + 32'h1FF);
                    b        = 27'(sent * 32'h0321FED + 32'h7FFFE00);
                    cin      = 1'(sent & 1);
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 6 && cyc < 10);
            #1;
            if (out_valid && !out_ready) begin
                check({tag, "_stall_in_ready"}, 64'(in_ready), 64'(0));
                if (was_stalled) check({tag, "_stall_hold"}, 64'(s), 64'(held));
                held        = s;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                check({tag, "_no_extra"}, 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check({tag, "_sum"}, 64'({cout, s}), 64'(e));
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                q.push_back({1'b0, a} + {1'b0, b} + 28'(cin));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_delivered"}, 64'(rcv), 64'(n));
    endtask

    initial begin
        int seen;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        check("rst_ov",   64'(out_valid), 64'(0));
        check("rst_s",    64'(s),         64'(0));
        check("rst_cout", 64'(cout),      64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'(1));

        run_op("lat",    27'd5,        27'd7,        1'b0, 27'd12,       1'b0, 1'b0);
        run_op("x9",     27'h1FF,      27'h1,        1'b0, 27'h200,      1'b0, 1'b0);
        run_op("x18",    27'h3FFFF,    27'h1,        1'b0, 27'h40000,    1'b0, 1'b0);
        run_op("cinx",   27'h1FF,      27'h3FE00,    1'b1, 27'h40000,    1'b0, 1'b0);
        run_op("wrap",   27'h7FFFFFF,  27'h0,        1'b1, 27'h0,        1'b1, 1'b0);
        run_op("negneg", 27'h4000000,  27'h4000000,  1'b0, 27'h0,        1'b1, 1'b1);
        run_op("pospos", 27'h3FFFFFF,  27'h3FFFFFF,  1'b0, 27'h7FFFFFE,  1'b0, 1'b1);
        run_op("mixed",  27'h5555555,  27'h2AAAAAA,  1'b1, 27'h0,        1'b1, 1'b0);

        // Two operations in flight, then an asynchronous reset between edges.
        in_valid = 1'b1;
        a        = 27'd100;
        b        = 27'd200;
        tick();
        a        = 27'd300;
        b        = 27'd400;
        tick();
        in_valid = 1'b0;
        #2;
        reset_n  = 1'b0;
        #1;
        check("midrst_ov", 64'(out_valid), 64'(0));
        check("midrst_s",  64'(s),         64'(0));
        tick();
        reset_n = 1'b1;
        seen    = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_stale", 64'(seen), 64'(0));

        stream("bp",  10,   1'b0);
        stream("rnd", 2000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
